// File: rtl/hilo_unit_if.sv
// hilo_unit_if: issue/result bundle between the decode stage and the HI/LO
// multiply/divide engine.
//   a, b   : 32-bit operands rs / rt
//   op     : 3-bit operation code (1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO)
//   start  : issue strobe, honoured only while busy is low
//   busy   : engine has a multiply/divide in flight
//   done   : one-cycle pulse when fresh results appear on hi/lo
//   hi, lo : architectural HI/LO registers
// master = issuing core, slave = hilo_unit.
interface hilo_unit_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output a, b, op, start,
        input  busy, done, hi, lo
    );

    modport slave (
        input  a, b, op, start,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_unit.sv
// hilo_unit: sequential 32x32 multiply / 32/32 divide engine holding the
// MIPS HI/LO registers. One shift-add or restoring-divide step per clock,
// 34 cycles from issue to visible result; MTHI/MTLO complete in one cycle.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset; aborts any operation in flight
//   bus  : hilo_unit_if slave (a, b, op, start in; busy, done, hi, lo out)
module hilo_unit (
    input  logic        clk,
    input  logic        rst,
    hilo_unit_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FINAL
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP0  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_NOP7  = 3'd7
    } op_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Working pair: multiply keeps {partial high, multiplier/product low},
    // divide keeps {remainder, dividend/quotient}. opnd is the multiplicand
    // or the divisor magnitude.
    logic [31:0] work_hi;
    logic [31:0] work_lo;
    logic [31:0] opnd;
    logic        is_div;
    logic        res_sign;   // product / quotient sign
    logic        rem_sign;   // remainder sign (divide only)

    // Combinational step and issue helpers
    op_t         op_in;
    logic        op_signed;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] div_sh;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] prod_neg;
    logic [31:0] quo_neg;
    logic [31:0] rem_neg;

    always_comb begin
        op_in     = op_t'(bus.op);
        op_signed = (op_in == OP_MULT) || (op_in == OP_DIV);
        mag_a     = (op_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
        mag_b     = (op_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

        // Shift-add: add multiplicand when the current multiplier LSB is 1,
        // then shift the 65-bit {carry, hi, lo} right by one.
        mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : 33'd0);

        // Restoring divide: shifted partial remainder is up to 33 bits wide.
        // When it is >= divisor the difference always fits in 32 bits.
        div_sh    = {work_hi, work_lo[31]};
        div_ge    = (div_sh >= {1'b0, opnd});
        div_sub   = div_sh[31:0] - opnd;

        prod_neg  = ~{work_hi, work_lo} + 64'd1;
        quo_neg   = ~work_lo + 32'd1;
        rem_neg   = ~work_hi + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            work_hi  <= '0;
            work_lo  <= '0;
            opnd     <= '0;
            is_div   <= 1'b0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        case (op_in)
                            OP_MTHI: hi_q <= bus.a;
                            OP_MTLO: lo_q <= bus.a;
                            OP_MULT, OP_MULTU: begin
                                work_hi  <= '0;
                                work_lo  <= mag_b;
                                opnd     <= mag_a;
                                is_div   <= 1'b0;
                                res_sign <= op_signed && (bus.a[31] ^ bus.b[31]);
                                rem_sign <= 1'b0;
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                                state    <= CALC;
                            end
                            OP_DIV, OP_DIVU: begin
                                work_hi  <= '0;
                                work_lo  <= mag_a;
                                opnd     <= mag_b;
                                is_div   <= 1'b1;
                                res_sign <= op_signed && (bus.a[31] ^ bus.b[31]);
                                rem_sign <= op_signed && bus.a[31];
                                cnt      <= '0;
                                busy_q   <= 1'b1;
                                state    <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end

                CALC: begin
                    if (is_div) begin
                        work_hi <= div_ge ? div_sub : div_sh[31:0];
                        work_lo <= {work_lo[30:0], div_ge};
                    end else begin
                        work_hi <= mul_sum[32:1];
                        work_lo <= {mul_sum[0], work_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FINAL;
                    end
                end

                FINAL: begin
                    if (is_div) begin
                        lo_q <= res_sign ? quo_neg : work_lo;
                        hi_q <= rem_sign ? rem_neg : work_hi;
                    end else begin
                        {hi_q, lo_q} <= res_sign ? prod_neg : {work_hi, work_lo};
                    end
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle multiply/divide engine with the architectural HI/LO registers for the MIPS-54 core. The decode stage issues MULT, MULTU, DIV, DIVU, MTHI and MTLO through a start/busy handshake. The core stalls on `busy` and reads results from the registered `hi`/`lo` outputs for MFHI/MFLO. It is the sequential counterpart to the single-cycle combinational multiply/divide path: one shift-add or restoring-divide step per clock, with no wide array logic.

## Interface
Parameters:
- none; datapath fixed at 32 bits, HI/LO at 32 bits each.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- `b`  in  32  operand rt (divisor / multiplier).
- `op`  in  3  operation code:
  - 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
  - 0 and 7 are no-ops.
- `start`  in  1  issue strobe; `op`, `a` and `b` are sampled only in a cycle where `start` is 1 and `busy` is 0.
- `busy`  out  1  high while a multiply/divide is in flight; the core must stall.
- `done`  out  1  one-cycle pulse in the first cycle in which new multiply/divide results are visible on `hi`/`lo`.
- `hi`  out  32  HI register (product[63:32] / remainder).
- `lo`  out  32  LO register (product[31:0] / quotient).

## Operation
- Reset: state is IDLE and counter is 0. `busy`=0, `done`=0, `hi`=0, `lo`=0.
- States: IDLE, CALC, FINAL.
- IDLE:
  - `start` with op 5 writes `hi`<=`a` at the edge; op 6 writes `lo`<=`a`. There is no busy and no done.
  - `start` with op 1-4 latches the operand magnitudes, the signed/unsigned flag, the mult/div flag and the result signs. It clears the counter and moves to CALC.
  - `start` with op 0 or 7 does nothing.
- Signed ops (MULT, DIV):
  - Operands are converted to 32-bit magnitudes (two's-complement absolute value; 0x80000000 gives magnitude 0x80000000).
  - Product sign and quotient sign = a[31]^b[31].
  - Remainder sign = a[31].
  - Unsigned ops use the operands as-is, with all signs 0.
- CALC runs 32 iterations; the counter counts 0..31 and the state moves to FINAL after iteration 31.
  - Multiply: 64-bit shift-add, LSB-first on the multiplier; 32-bit adder with a carry into the upper half.
  - Divide: restoring division, MSB-first. Each step shifts the {remainder, quotient} pair left 1 and trial-subtracts the divisor. If there is no borrow, it keeps the difference and sets the quotient bit.
- FINAL:
  - Applies sign correction: 64-bit negation of the product, 32-bit negation of the quotient and remainder, each where its sign is 1.
  - Writes `hi`/`lo`, returns to IDLE and sets `done` for one cycle.
- Divide by zero is not trapped and takes the full latency. The unsigned core yields quotient 0xFFFFFFFF and remainder = dividend magnitude, then sign correction applies:
  - DIVU x/0 gives `lo`=0xFFFFFFFF, `hi`=x.
  - DIV gives `hi`=a, and `lo`=0xFFFFFFFF for a>=0 or 0x00000001 for a<0.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0. This is not flagged.
- `hi`/`lo` hold their previous values throughout CALC; the only intermediate storage is internal.

## Timing
- `start` accepted in cycle T:
  - `busy`=1 in cycles T+1..T+33.
  - Results are written at the edge ending T+33.
  - `done`=1 and new `hi`/`lo` are visible in cycle T+34, with `busy`=0.
- Multiply/divide latency is 34 cycles from issue to usable result, independent of operand values.
- A new `start` may be accepted in cycle T+34, the same cycle `done` is high.
- `start` while `busy`=1 is ignored entirely, including MTHI/MTLO. The core is required not to issue then.
- MTHI/MTLO: the value is visible on the cycle after issue.
- `busy` and `done` are registered outputs with no combinational path from the inputs.
- `rst` in any cycle, including mid-CALC or during FINAL, aborts the operation. At the next edge, all outputs return to their reset values and no partial result is written.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF:
  - `busy` high 33 cycles, `done` at T+34.
  - `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT a=0xFFFFFFFD (-3), b=5 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Then MULT 0x80000000 x 0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV a=0xFFFFFFF9 (-7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 7/2 -> `lo`=3, `hi`=1.
- Boundary cases:
  - DIVU 100/0 -> `lo`=0xFFFFFFFF, `hi`=100.
  - DIV -5/0 -> `lo`=1, `hi`=0xFFFFFFFB.
  - DIV 0x80000000/0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MTHI a=0x12345678 in IDLE -> `hi`=0x12345678 next cycle, no `busy`, no `done`. During a running DIVU, issue MTLO and a second MULT -> both ignored, and the DIVU result and timing are unchanged.
- Reset mid-operation:
  - Start MULTU 3x4; assert `rst` in cycle T+10 -> `busy`/`done`/`hi`/`lo` all 0 next cycle, with no later `done`.
  - A fresh MULTU 3x4 after reset gives `lo`=12 at T'+34.
